// File: rtl/lim_mem_readback.sv
// rtl/lim_mem_readback.sv - port-B sequential read-back engine for the LiM/racetrack data memory
// Optional macro READBACK_TIMEOUT_EN: abandon the dump when a word's rvalid_b_i never arrives.
module lim_mem_readback #(
  parameter int RAM_ADDR_WIDTH = 22,
  parameter int CNT_WIDTH      = 16,
  parameter int FUNCT_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [RAM_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [CNT_WIDTH-1:0]      num_words_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic                      en_b_o,
  output logic [RAM_ADDR_WIDTH-1:0] addr_b_o,
  output logic                      we_b_o,
  output logic [3:0]                be_b_o,
  output logic [31:0]               wdata_b_o,
  output logic [FUNCT_WIDTH-1:0]    logic_in_memory_funct_o,
  output logic                      we_b_funct_mem_o,
  output logic [RAM_ADDR_WIDTH-1:0] addr_b_range_o,
  input  logic                      rvalid_b_i,
  input  logic [31:0]               rdata_b_i,
  output logic [31:0]               data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic [CNT_WIDTH-1:0]      word_idx_o,
  output logic [31:0]               checksum_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                    state;
  logic [RAM_ADDR_WIDTH-1:0] addr;
  logic [RAM_ADDR_WIDTH-1:0] addr_next;
  logic [RAM_ADDR_WIDTH-1:0] start_addr_aligned;
  logic [CNT_WIDTH-1:0]      remaining;

  // Port B is used read-only, full-word, with no logic-in-memory operation.
  assign we_b_o                  = 1'b0;
  assign be_b_o                  = 4'b1111;
  assign wdata_b_o               = 32'h0;
  assign logic_in_memory_funct_o = '0;
  assign we_b_funct_mem_o        = 1'b0;
  assign addr_b_range_o          = '0;

  assign addr_next          = addr + RAM_ADDR_WIDTH'(4);
  assign start_addr_aligned = start_addr_i & ~RAM_ADDR_WIDTH'(3);

`ifdef READBACK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              error_q;
  logic              timeout;
  // The last allowed WAIT cycle is the one where the counter shows TIMEOUT_CYCLES-1.
  assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      addr         <= '0;
      remaining    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      en_b_o       <= 1'b0;
      addr_b_o     <= '0;
      data_o       <= 32'h0;
      data_valid_o <= 1'b0;
      word_idx_o   <= '0;
      checksum_o   <= 32'h0;
`ifdef READBACK_TIMEOUT_EN
      wait_cnt     <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      en_b_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_o   <= 1'b0;
          addr_b_o <= '0;
          if (start_i) begin
            busy_o     <= 1'b1;
            addr       <= start_addr_aligned;
            remaining  <= num_words_i;
            checksum_o <= 32'h0;
            word_idx_o <= '0;
`ifdef READBACK_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
            if (num_words_i == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_REQ;
              en_b_o   <= 1'b1;
              addr_b_o <= start_addr_aligned;
            end
          end
        end
        S_REQ: begin
          state <= S_WAIT;
`ifdef READBACK_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (rvalid_b_i) begin
            data_o       <= rdata_b_i;
            data_valid_o <= 1'b1;
            state        <= S_OUT;
          end
`ifdef READBACK_TIMEOUT_EN
          else if (timeout) begin
            error_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        S_OUT: begin
          if (data_ready_i) begin
            data_valid_o <= 1'b0;
            checksum_o   <= checksum_o + data_o;
            word_idx_o   <= word_idx_o + CNT_WIDTH'(1);
            remaining    <= remaining - CNT_WIDTH'(1);
            addr         <= addr_next;
            if (remaining == CNT_WIDTH'(1)) begin
              state <= S_DONE;
            end else begin
              state    <= S_REQ;
              en_b_o   <= 1'b1;
              addr_b_o <= addr_next;
            end
          end
        end
        S_DONE: begin
          // busy_o stays high through the done_o cycle; IDLE drops it next.
          done_o   <= 1'b1;
          addr_b_o <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lim_mem_readback.sv
// tb/tb_lim_mem_readback.sv - directed and randomized bench for lim_mem_readback against a memory-map model
module tb_lim_mem_readback;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [21:0] start_addr_i;
  logic [15:0] num_words_i;
  logic        busy_o, done_o, error_o, en_b_o, we_b_o, we_b_funct_mem_o;
  logic [21:0] addr_b_o, addr_b_range_o;
  logic [3:0]  be_b_o;
  logic [31:0] wdata_b_o, data_o, checksum_o;
  logic [2:0]  logic_in_memory_funct_o;
  logic        rvalid_b_i;
  logic [31:0] rdata_b_i;
  logic        data_valid_o, data_ready_i;
  logic [15:0] word_idx_o;

  always #5 clk_i = ~clk_i;

  lim_mem_readback #(
    .RAM_ADDR_WIDTH(22), .CNT_WIDTH(16), .FUNCT_WIDTH(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .start_addr_i(start_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .en_b_o(en_b_o), .addr_b_o(addr_b_o), .we_b_o(we_b_o), .be_b_o(be_b_o),
    .wdata_b_o(wdata_b_o), .logic_in_memory_funct_o(logic_in_memory_funct_o),
    .we_b_funct_mem_o(we_b_funct_mem_o), .addr_b_range_o(addr_b_range_o),
    .rvalid_b_i(rvalid_b_i), .rdata_b_i(rdata_b_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .word_idx_o(word_idx_o), .checksum_o(checksum_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [logic [21:0]];

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Port-B responder: answers each en_b_o after lat cycles, optionally injects stray rvalid.
  int          lat = 2;
  int          resp_limit = 1 << 30;
  int          resp_given = 0;
  bit          spur_out = 0;
  bit          spur_any = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic [21:0] paddr = '0;

  initial begin
    rvalid_b_i = 1'b0;
    rdata_b_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      rvalid_b_i = 1'b0;
      rdata_b_i  = 32'h0;
      if (!rst_ni) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            rvalid_b_i = 1'b1;
            rdata_b_i  = mem_word(paddr);
            pend       = 0;
            resp_given++;
          end
        end
        if (!rvalid_b_i && ((spur_out && data_valid_o) || spur_any)) begin
          rvalid_b_i = 1'b1;
          rdata_b_i  = 32'hDEAD_BEEF;
        end
        if (en_b_o && resp_given < resp_limit) begin
          pend  = 1;
          paddr = addr_b_o;
          cnt   = lat;
        end
      end
    end
  end

  // Observer: logs port-B requests, delivered words, done pulses and constant-output violations.
  logic [21:0] en_addrs [$];
  logic [31:0] words [$];
  int          done_cnt  = 0;
  int          const_bad = 0;

  always @(negedge clk_i) begin
    if (en_b_o) en_addrs.push_back(addr_b_o);
    if (data_valid_o && data_ready_i) words.push_back(data_o);
    if (done_o) done_cnt++;
    if (we_b_o !== 1'b0 || be_b_o !== 4'hF || wdata_b_o !== 32'h0 ||
        logic_in_memory_funct_o !== 3'h0 || we_b_funct_mem_o !== 1'b0 || addr_b_range_o !== 22'h0)
      const_bad++;
  end

  // mode 0: always ready, 1: random ready, 2: 10-cycle stall on word 1, 3: disturbances
  task automatic run_read(input string tag, input logic [21:0] sa, input int n, input int mode,
                          input bit expect_err, input int n_ok);
    int          en_base = en_addrs.size();
    int          wd_base = words.size();
    int          dn_base = done_cnt;
    bit          seen_done = 0;
    int          hold = 0;
    int          en_at_hold = 0;
    logic [31:0] held = '0;
    logic [31:0] sum = '0;
    logic [21:0] a;
    int          n_req = expect_err ? n_ok + 1 : n;

    start_addr_i = sa;
    num_words_i  = 16'(n);
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      data_ready_i = 1'b1;
      if (mode == 1 || mode == 3) data_ready_i = 1'($urandom % 2);
      if (mode == 3) begin
        start_i      = busy_o && !done_o && ($urandom % 3 == 0);
        start_addr_i = 22'($urandom);
        num_words_i  = 16'($urandom % 5);
      end
      if (mode == 2 && data_valid_o && word_idx_o == 16'd1 && hold <= 10) begin
        if (hold == 0) begin
          held       = data_o;
          en_at_hold = en_addrs.size();
        end else begin
          chk({tag, " bp_data_hold"}, data_o, held);
          chk({tag, " bp_idx_hold"}, word_idx_o, 1);
        end
        if (hold == 10) chk({tag, " bp_no_new_en"}, en_addrs.size(), en_at_hold);
        data_ready_i = (hold == 10);
        hold++;
      end
      step();
      if (done_cnt > dn_base) seen_done = 1;
    end
    start_i      = 1'b0;
    data_ready_i = 1'b1;
    step();
    step();
    chk({tag, " done_seen"}, seen_done, 1);
    if (mode == 2) chk({tag, " bp_stall_done"}, hold, 11);
    chk({tag, " en_count"}, en_addrs.size() - en_base, n_req);
    chk({tag, " word_count"}, words.size() - wd_base, n_ok);
    for (int i = 0; i < n_req && en_base + i < en_addrs.size(); i++) begin
      a = (sa & ~22'h3) + 22'(4 * i);
      chk({tag, $sformatf(" addr%0d", i)}, en_addrs[en_base + i], a);
      if (i < n_ok && wd_base + i < words.size()) begin
        chk({tag, $sformatf(" word%0d", i)}, words[wd_base + i], mem_word(a));
        sum += mem_word(a);
      end
    end
    chk({tag, " checksum"}, checksum_o, sum);
    chk({tag, " word_idx"}, word_idx_o, n_ok);
    chk({tag, " done_pulses"}, done_cnt - dn_base, 1);
    chk({tag, " error"}, error_o, expect_err);
    chk({tag, " idle"}, {busy_o, data_valid_o}, 2'b00);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int en_base;
    int n;

    rst_ni       = 1'b0;
    start_i      = 1'b0;
    start_addr_i = '0;
    num_words_i  = '0;
    data_ready_i = 1'b1;
    repeat (3) step();
    chk("reset busy/done/err/en/valid", {busy_o, done_o, error_o, en_b_o, data_valid_o}, 5'b0);
    chk("reset be_b", be_b_o, 4'hF);
    chk("reset addr_b", addr_b_o, 0);
    chk("reset data/checksum", {data_o, checksum_o}, 64'h0);
    chk("reset word_idx", word_idx_o, 0);
    rst_ni = 1'b1;
    step();

    mem[22'h180] = 32'h1111_1111;
    mem[22'h184] = 32'h2222_2222;
    mem[22'h188] = 32'h3333_3333;
    lat = 2;
    run_read("basic", 22'h180, 3, 0, 0, 3);
    chk("basic checksum literal", checksum_o, 32'h6666_6666);

    // Zero count: no port-B traffic, busy two cycles, done in the second.
    en_base      = en_addrs.size();
    num_words_i  = '0;
    start_i      = 1'b1;
    step();
    start_i  = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (done_o) done_at = k;
      step();
    end
    chk("zero busy_cycles", busy_cnt, 2);
    chk("zero done_cycle", done_at, 2);
    chk("zero no_en", en_addrs.size(), en_base);

    lat = 3;
    run_read("backpressure", 22'h1000, 3, 2, 0, 3);
    lat = 1;
    run_read("wrap", 22'h3FFFFD, 2, 0, 0, 2);
    chk("wrap second addr", en_addrs[en_addrs.size() - 1], 22'h000000);

    for (int r = 0; r < 4; r++) begin
      n   = $urandom_range(1, 6);
      lat = $urandom_range(1, 5);
      run_read($sformatf("rand%0d", r), 22'($urandom), n, 1, 0, n);
    end

    spur_out = 1;
    lat      = 2;
    run_read("disturb", 22'h2A4, 4, 3, 0, 4);
    spur_out = 0;

`ifdef READBACK_TIMEOUT_EN
    resp_limit = resp_given + 2;
    run_read("timeout", 22'h200, 4, 0, 1, 2);
    resp_limit = 1 << 30;
    run_read("after_timeout", 22'h300, 1, 0, 0, 1);
`endif

    // Reset while waiting on a word that never arrives.
    resp_limit   = resp_given;
    start_addr_i = 22'h40;
    num_words_i  = 16'd3;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    chk("mid busy before reset", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid reset busy/done/err/en/valid", {busy_o, done_o, error_o, en_b_o, data_valid_o}, 5'b0);
    chk("mid reset addr_b", addr_b_o, 0);
    chk("mid reset data/checksum", {data_o, checksum_o}, 64'h0);
    chk("mid reset word_idx", word_idx_o, 0);
    chk("mid reset be_b", be_b_o, 4'hF);
    step();
    step();
    rst_ni     = 1'b1;
    resp_limit = 1 << 30;
    en_base    = en_addrs.size();
    spur_any   = 1;
    repeat (4) step();
    spur_any = 0;
    step();
    chk("post reset rvalid ignored", {busy_o, data_valid_o, en_b_o}, 3'b0);
    chk("post reset data_o", data_o, 0);
    chk("post reset no_en", en_addrs.size(), en_base);

    lat = 2;
    run_read("post_reset", 22'h180, 3, 0, 0, 3);
    chk("constant port-B outputs", const_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
